dcache_line_responder: RTL and testbench
========================================

# dcache_line_responder

Memory-side responder for the commit-time data-memory handshake. It accepts the word-level load/store requests the reorder buffer raises at commit (`data_read`/`data_write`, `wmask`, held until `data_mem_resp`) and answers each with exactly one registered response pulse. Requests are served from a single 256-bit line buffer. Misses trigger a write-back, if the buffered line is dirty, followed by a line fill over the physical-memory burst interface.

## Interface
- No parameters. Line is 32 B (8 words); tag is `addr[31:5]`.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `data_read` in 1: load request, level, held until response.
- `data_write` in 1: store request, level, held until response.
- `data_addr` in 32: byte address; `[4:2]` selects the word.
- `wmask` in 4: byte enables for stores, already shifted to lane position.
- `data_wdata` in 32: store data, already lane-aligned.
- `data_rdata` out 32: load word, registered.
- `data_mem_resp` out 1: one-cycle completion pulse.
- `pmem_read` out 1: line fill request, held until `pmem_resp`.
- `pmem_write` out 1: line write-back request, held until `pmem_resp`.
- `pmem_address` out 32: line address, low 5 bits are zero.
- `pmem_wdata` out 256: write-back line.
- `pmem_rdata` in 256: fill line, valid when `pmem_resp` is high.
- `pmem_resp` in 1: memory completion pulse.

## Operation
- Internal state: `lb_valid`, `lb_dirty`, `lb_tag[26:0]`, `lb_data[255:0]`, `miss_addr[31:5]`, and FSM states IDLE, WB, FILL, RESP.
- A request is `data_read | data_write`. If both are high, the read takes priority and the write is ignored; this combination is illegal and the bench flags it.
- **IDLE**
  - On a hit (request with `lb_valid` and `lb_tag == data_addr[31:5]`), go to RESP.
    - A read loads `data_rdata` with `lb_data` word `data_addr[4:2]`.
    - A write merges the enabled bytes of `data_wdata` into that word and sets `lb_dirty`.
    - Both updates happen on this transition edge.
  - On a miss, latch `miss_addr`. Go to WB if `lb_valid & lb_dirty`, otherwise go to FILL.
  - With no request, stay in IDLE.
- **WB**
  - `pmem_write=1`, `pmem_address={lb_tag,5'b0}`, `pmem_wdata=lb_data`.
  - On `pmem_resp`, clear `lb_dirty` and go to FILL.
- **FILL**
  - `pmem_read=1`, `pmem_address={miss_addr,5'b0}`.
  - On `pmem_resp`, load `lb_data` from `pmem_rdata`, set `lb_tag=miss_addr`, `lb_valid=1`, `lb_dirty=0`, and go to IDLE. The request is then re-evaluated there and hits.
- **RESP**
  - `data_mem_resp=1` for this single cycle, then return to IDLE unconditionally.
- `data_mem_resp` is a pure function of state and never depends combinationally on request inputs. This is required because the requester deasserts its request combinationally on the response.
- If the request drops while in WB or FILL, the pmem transaction still completes. The FSM then returns to IDLE and no response is issued.
- The requester holds `data_addr`, `wmask` and `data_wdata` stable from request assertion through the RESP cycle.
- `pmem_read` and `pmem_write` are never asserted together.

## Timing
- Reset (async, takes effect immediately):
  - FSM = IDLE; `lb_valid=0`, `lb_dirty=0`.
  - `data_mem_resp=0`, `pmem_read=0`, `pmem_write=0`, `data_rdata=0`, `pmem_address=0`.
- Hit: request seen in IDLE at cycle 0, response in cycle 1. Latency 1.
- Clean miss:
  - `pmem_read` is asserted from cycle 1.
  - `pmem_resp` arrives at cycle k.
  - IDLE at k+1, response at k+2.
- Dirty miss: the WB phase comes first. `pmem_read` rises the cycle after the write-back's `pmem_resp`.
- Back-to-back: the earliest new hit response is 2 cycles after the previous one (RESP, IDLE, RESP).
- `data_rdata` holds its value until the next read hit.
- Reset during WB or FILL aborts the transaction: pmem outputs drop immediately and the buffered line is discarded, including any dirty data.

## Test plan
- Reset, then read `0x100`; memory returns a line with word0 `0xDEADBEEF` three cycles after `pmem_read` -> `pmem_address=0x100`, no `pmem_write`, one `data_mem_resp` 2 cycles after `pmem_resp`, `data_rdata=0xDEADBEEF`.
- Then read `0x104` (line word1 `0x11223344`) -> response in cycle 1, `data_rdata=0x11223344`, `pmem_read`/`pmem_write` stay 0.
- Write `0x108`, `wmask=0011`, `wdata=0x00001234`, over old word `0xAABBCCDD` -> response in cycle 1; a following read of `0x108` returns `0xAABB1234`.
- Byte store to `0x108`, `wmask=0100`, `wdata=0x00EE0000` -> a following read returns `0xAAEE1234`.
- With the line dirty, read `0x200` -> `pmem_write` with address `0x100` and `pmem_wdata` word2 `0xAAEE1234`; after its `pmem_resp`, `pmem_read` with address `0x200`; a single response follows.
- Assert `rst` mid-FILL -> `pmem_read` and `data_mem_resp` drop the same cycle; a subsequent read of `0x200` misses again and issues a FILL.

Source files
------------

// File: rtl/dcache_line_responder_if.sv
// Commit-side data request bus plus physical-memory line burst bus.
// slave: responder view; master: requester and memory view.
interface dcache_line_responder_if;
  logic         data_read;
  logic         data_write;
  logic [31:0]  data_addr;
  logic [3:0]   wmask;
  logic [31:0]  data_wdata;
  logic [31:0]  data_rdata;
  logic         data_mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  data_read, data_write, data_addr,
    input  wmask, data_wdata,
    output data_rdata, data_mem_resp,
    output pmem_read, pmem_write,
    output pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output data_read, data_write, data_addr,
    output wmask, data_wdata,
    input  data_rdata, data_mem_resp,
    input  pmem_read, pmem_write,
    input  pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/dcache_line_responder.sv
// Single-line write-back buffer answering commit loads/stores.
// Ports: clk, rst (async high), bus (slave: data req + pmem burst).
module dcache_line_responder (
  input logic              clk,
  input logic              rst,
  dcache_line_responder_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, WB, FILL, RESP
  } state_t;

  state_t         state_q, state_d;
  logic           lb_valid;
  logic           lb_dirty;
  logic [26:0]    lb_tag;
  logic [26:0]    miss_addr;
  logic [255:0]   lb_data;
  logic [31:0]    rdata_q;

  logic           req;
  logic           hit;
  logic [7:0]     wofs;
  logic [31:0]    cur_w;
  logic [31:0]    new_w;

  logic           pmem_read;
  logic           pmem_write;
  logic [31:0]    pmem_address;
  logic           resp;

  assign req   = bus.data_read | bus.data_write;
  assign hit   = req & lb_valid &
                 (lb_tag == bus.data_addr[31:5]);
  assign wofs  = {bus.data_addr[4:2], 5'b0};
  assign cur_w = lb_data[wofs +: 32];

  always_comb begin
    new_w = cur_w;
    for (int i = 0; i < 4; i++) begin
      if (bus.wmask[i]) begin
        new_w[8*i +: 8] = bus.data_wdata[8*i +: 8];
      end
    end
  end

  // Response is decoded from state only; the
  // requester drops its request on it.
  always_comb begin
    state_d      = state_q;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    resp         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          state_d = RESP;
        end else if (req) begin
          state_d = (lb_valid & lb_dirty) ? WB : FILL;
        end
      end
      WB: begin
        pmem_write   = 1'b1;
        pmem_address = {lb_tag, 5'b0};
        if (bus.pmem_resp) state_d = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {miss_addr, 5'b0};
        if (bus.pmem_resp) state_d = IDLE;
      end
      RESP: begin
        resp    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lb_valid  <= 1'b0;
      lb_dirty  <= 1'b0;
      lb_tag    <= '0;
      miss_addr <= '0;
      lb_data   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (hit && bus.data_read) begin
          rdata_q <= cur_w;
        end else if (hit) begin
          lb_data[wofs +: 32] <= new_w;
          lb_dirty            <= 1'b1;
        end else if (req) begin
          miss_addr <= bus.data_addr[31:5];
        end
      end
      if (state_q == WB && bus.pmem_resp) begin
        lb_dirty <= 1'b0;
      end
      if (state_q == FILL && bus.pmem_resp) begin
        lb_data  <= bus.pmem_rdata;
        lb_tag   <= miss_addr;
        lb_valid <= 1'b1;
        lb_dirty <= 1'b0;
      end
    end
  end

  assign bus.data_rdata    = rdata_q;
  assign bus.data_mem_resp = resp;
  assign bus.pmem_read     = pmem_read;
  assign bus.pmem_write    = pmem_write;
  assign bus.pmem_address  = pmem_address;
  assign bus.pmem_wdata    = lb_data;
endmodule

// File: tb/tb_dcache_line_responder.sv
// Bench for dcache_line_responder: word-level memory model,
// residency model and a latency-programmable pmem responder.
module tb_dcache_line_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_line_responder_if bus();

  dcache_line_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  logic [255:0] mem [32];
  logic [31:0]  gold [256];
  logic [31:0]  last_rdata;

  int mem_lat    = 3;
  int n_wb       = 0;
  int n_fill     = 0;
  int n_overlap  = 0;
  int n_misalign = 0;
  int resp_cyc   = 0;
  int wb_cyc     = 0;
  int fill_start = 0;
  logic [31:0] wb_addr, fill_addr;

  bit          res_valid = 0;
  bit          res_dirty = 0;
  logic [26:0] res_tag   = '0;

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] gold_line(input int li);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = gold[li*8 + w];
    return l;
  endfunction

  initial begin
    int cnt;
    int li;
    cnt = -1;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      if (bus.pmem_read && bus.pmem_write) n_overlap++;
      if ((bus.pmem_read || bus.pmem_write) &&
          bus.pmem_address[4:0] != 5'd0) n_misalign++;
      if (rst || !(bus.pmem_read || bus.pmem_write)) begin
        cnt = -1;
      end else begin
        if (cnt < 0) begin
          cnt = mem_lat;
          if (bus.pmem_read) fill_start = cyc;
        end
        if (cnt == 0) begin
          li = int'(bus.pmem_address[9:5]);
          bus.pmem_resp = 1'b1;
          resp_cyc = cyc;
          if (bus.pmem_write) begin
            mem[li] = bus.pmem_wdata;
            n_wb++;
            wb_addr = bus.pmem_address;
            wb_cyc  = cyc;
          end else begin
            bus.pmem_rdata = mem[li];
            n_fill++;
            fill_addr = bus.pmem_address;
          end
          cnt = -1;
        end else begin
          cnt--;
        end
      end
    end
  end

  task automatic do_req(input bit rd, input bit wr,
                        input logic [31:0] a,
                        input logic [3:0] m,
                        input logic [31:0] d);
    int c0, nwb0, nf0, wi;
    bit got, ehit, ewb;
    logic [26:0] old_tag;
    wi      = int'(a[9:2]);
    old_tag = res_tag;
    ehit    = res_valid && (res_tag == a[31:5]);
    ewb     = !ehit && res_valid && res_dirty;
    nwb0    = n_wb;
    nf0     = n_fill;
    chk("rd_wr_excl", rd & wr, 1'b0);
    @(posedge clk);
    #1;
    bus.data_read  = rd;
    bus.data_write = wr;
    bus.data_addr  = a;
    bus.wmask      = m;
    bus.data_wdata = d;
    c0  = cyc;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (bus.data_mem_resp) got = 1;
    end
    chk("resp_seen", got, 1'b1);
    if (ehit) chk("hit_lat", cyc - c0, 1);
    else      chk("miss_lat", cyc, resp_cyc + 2);
    chk("wb_cnt", n_wb - nwb0, ewb);
    chk("fill_cnt", n_fill - nf0, !ehit);
    if (!ehit) begin
      chk("fill_addr", fill_addr, {a[31:5], 5'b0});
      chk("fill_start", fill_start,
          ewb ? wb_cyc + 1 : c0 + 1);
    end
    if (ewb) begin
      chk("wb_addr", wb_addr, {old_tag, 5'b0});
      chk("wb_line", mem[int'(old_tag[4:0])],
          gold_line(int'(old_tag[4:0])));
    end
    if (!ehit) begin
      res_valid = 1;
      res_tag   = a[31:5];
      res_dirty = 0;
    end
    if (rd) begin
      last_rdata = gold[wi];
      chk("rdata", bus.data_rdata, last_rdata);
    end else begin
      for (int b = 0; b < 4; b++)
        if (m[b]) gold[wi][8*b +: 8] = d[8*b +: 8];
      res_dirty = 1;
      chk("rdata_hold", bus.data_rdata, last_rdata);
    end
    @(posedge clk);
    #1;
    bus.data_read  = 1'b0;
    bus.data_write = 1'b0;
    @(negedge clk);
    chk("resp_pulse", bus.data_mem_resp, 1'b0);
  endtask

  initial begin
    bit ok;
    int li;
    logic [31:0] a;
    for (int l = 0; l < 32; l++)
      for (int w = 0; w < 8; w++)
        gold[l*8 + w] = $urandom;
    gold[64] = 32'hDEADBEEF;
    gold[65] = 32'h11223344;
    gold[66] = 32'hAABBCCDD;
    for (int l = 0; l < 32; l++) mem[l] = gold_line(l);
    last_rdata = '0;

    rst            = 1'b1;
    bus.data_read  = 1'b0;
    bus.data_write = 1'b0;
    bus.data_addr  = '0;
    bus.wmask      = '0;
    bus.data_wdata = '0;
    #1;
    chk("rst_resp", bus.data_mem_resp, 1'b0);
    chk("rst_pread", bus.pmem_read, 1'b0);
    chk("rst_pwrite", bus.pmem_write, 1'b0);
    chk("rst_rdata", bus.data_rdata, 32'h0);
    chk("rst_paddr", bus.pmem_address, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    mem_lat = 3;
    do_req(1, 0, 32'h100, 4'h0, 32'h0);
    chk("dir_w0", last_rdata, 32'hDEADBEEF);
    do_req(1, 0, 32'h104, 4'h0, 32'h0);
    chk("dir_w1", last_rdata, 32'h11223344);
    do_req(0, 1, 32'h108, 4'b0011, 32'h00001234);
    do_req(1, 0, 32'h108, 4'h0, 32'h0);
    chk("dir_half", last_rdata, 32'hAABB1234);
    do_req(0, 1, 32'h108, 4'b0100, 32'h00EE0000);
    do_req(1, 0, 32'h108, 4'h0, 32'h0);
    chk("dir_byte", last_rdata, 32'hAAEE1234);
    do_req(1, 0, 32'h200, 4'h0, 32'h0);
    chk("dir_wb_w2", mem[8][95:64], 32'hAAEE1234);

    mem_lat = 10;
    @(posedge clk);
    #1;
    bus.data_read = 1'b1;
    bus.data_addr = 32'h300;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.pmem_read) ok = 1;
    end
    chk("fill_pending", ok, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort_pread", bus.pmem_read, 1'b0);
    chk("abort_pwrite", bus.pmem_write, 1'b0);
    chk("abort_resp", bus.data_mem_resp, 1'b0);
    chk("abort_rdata", bus.data_rdata, 32'h0);
    bus.data_read = 1'b0;
    if (res_valid && res_dirty) begin
      li = int'(res_tag[4:0]);
      for (int w = 0; w < 8; w++)
        gold[li*8 + w] = mem[li][32*w +: 32];
    end
    res_valid  = 0;
    res_dirty  = 0;
    last_rdata = '0;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    mem_lat = 2;
    do_req(1, 0, 32'h200, 4'h0, 32'h0);

    for (int n = 0; n < 200; n++) begin
      mem_lat = $urandom_range(0, 4);
      a = {22'd0, 5'($urandom_range(8, 13)),
           3'($urandom_range(0, 7)), 2'b00};
      if ($urandom_range(0, 1) == 1)
        do_req(1, 0, a, 4'h0, 32'h0);
      else
        do_req(0, 1, a, 4'($urandom), $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    chk("pmem_excl", n_overlap, 0);
    chk("pmem_align", n_misalign, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
